trng_parallel_n: RTL and testbench

TRNG_PARALLEL_N -- requirements
Module: trng_parallel_n

---
 rtl/trng_parallel_n.sv | 184 ++++++++++++++++++
 tb/tb_trng_parallel_n.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/trng_parallel_n.sv
// trng_parallel_n: WIDTH parallel TRNG lanes. Each capture takes one masked
// word from the lanes, runs a repetition-count health test on it and queues
// it in a small output FIFO.
// trng: behavioural single-lane entropy cell used by the array.

module trng (
   input  logic       clk,
   input  logic       reset,
   input  logic       d1,
   input  logic       d2,
   input  logic [4:0] d3,
   output logic       o_valid,
   output logic       o_warbler
);

   // Each clock, register the entropy bit (scrambled by the parity of the
   // control input) and the valid strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_valid   <= 1'b0;
         o_warbler <= 1'b0;
      end else begin
         o_valid   <= d2;
         o_warbler <= d1 ^ (^d3);
      end
   end

endmodule

module trng_parallel_n #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int RCT_LIMIT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           d1,
   input  logic [WIDTH-1:0]           d2,
   input  logic [4:0]                 d3,
   input  logic [WIDTH-1:0]           lane_en,
   input  logic                       en,
   input  logic                       health_clr,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [7:0]                 drop_cnt,
   output logic                       health_fail
);

   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int RW = $clog2(RCT_LIMIT);
   localparam logic [RW-1:0] REP_MAX = RW'(RCT_LIMIT - 1);

   logic [WIDTH-1:0] cell_valid;
   logic [WIDTH-1:0] cell_word;
   logic             all_valid;
   logic             all_valid_q;
   logic             capture;
   logic [WIDTH-1:0] masked_word;

   logic [WIDTH-1:0] prev_word;
   logic             prev_held;
   logic [RW-1:0]    rep_cnt;
   logic [RW-1:0]    rep_next;
   logic             first_cap;
   logic             same_word;
   logic             active;
   logic             trip;
   logic             push;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             pop;
   logic             accept;
   logic             drop;

   // Lane cells are held in reset for as long as the block reset is low.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      trng u_cell (
         .clk       (clk),
         .reset     (~rst),
         .d1        (d1[i]),
         .d2        (d2[i]),
         .d3        (d3 ^ 5'(i)),
         .o_valid   (cell_valid[i]),
         .o_warbler (cell_word[i])
      );
   end

   // Disabled lanes count as valid and contribute zero bits.
   always_comb begin
      all_valid   = &(cell_valid | ~lane_en);
      masked_word = cell_word & lane_en;
      capture     = en & all_valid & ~all_valid_q;
   end

   // Edge detector history runs every cycle so an edge seen while en=0 is consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) all_valid_q <= 1'b0;
      else      all_valid_q <= all_valid;
   end

   // Health-test decision for the current capture; a clear in the same cycle
   // makes this capture the first one, so it bypasses a pending failure.
   always_comb begin
      first_cap = health_clr | ~prev_held;
      same_word = (masked_word == prev_word);
      rep_next  = '0;
      if (!first_cap && same_word)
         rep_next = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + RW'(1);
      active = capture & (health_clr | ~health_fail);
      trip   = active & ~first_cap & (rep_next == REP_MAX);
      push   = active & ~trip;
   end

   // Repetition-count state and the sticky failure flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_word   <= '0;
         prev_held   <= 1'b0;
         rep_cnt     <= '0;
         health_fail <= 1'b0;
      end else begin
         if (health_clr) begin
            prev_held   <= 1'b0;
            rep_cnt     <= '0;
            health_fail <= 1'b0;
         end
         if (active) begin
            prev_word <= masked_word;
            prev_held <= 1'b1;
            rep_cnt   <= rep_next;
            if (trip) health_fail <= 1'b1;
         end
      end
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      out_valid = (level != '0);
      full      = (level == LW'(DEPTH));
      pop       = out_valid & out_ready;
      accept    = push & (~full | pop);
      drop      = push & full & ~pop;
      out_data  = out_valid ? mem[rd_ptr] : '0;
   end

   // FIFO storage; no reset needed because out_data is gated by occupancy.
   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= masked_word;
   end

   // Pointers and occupancy; a health trip empties the FIFO outright.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (trip) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         case ({accept, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Saturating count of captures lost to a full FIFO.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                          drop_cnt <= 8'd0;
      else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
   end

endmodule

// File: tb/tb_trng_parallel_n.sv
// Directed bench for trng_parallel_n with a scoreboard of expected FIFO words.

module tb_trng_parallel_n;

   localparam logic [31:0] ALL = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] d1 = '0;
   logic [31:0] d2 = '0;
   logic [4:0]  d3 = '0;
   logic [31:0] lane_en = ALL;
   logic        en = 1'b1;
   logic        health_clr = 1'b0;
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [31:0] out_data;
   logic [2:0]  level;
   logic [7:0]  drop_cnt;
   logic        health_fail;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] q[$];
   logic        pre_valid;
   logic [31:0] pre_head;
   logic [31:0] words[6];
   logic [31:0] rct_word;

   trng_parallel_n #(.WIDTH(32), .DEPTH(4), .RCT_LIMIT(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .d1          (d1),
      .d2          (d2),
      .d3          (d3),
      .lane_en     (lane_en),
      .en          (en),
      .health_clr  (health_clr),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .level       (level),
      .drop_cnt    (drop_cnt),
      .health_fail (health_fail)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Cell model: lane i outputs raw[i] xor parity(d3 ^ i), masked by lane_en.
   function automatic logic [31:0] model_word(input logic [31:0] raw,
                                              input logic [4:0] d3v,
                                              input logic [31:0] len);
      logic [31:0] m;
      for (int i = 0; i < 32; i++) begin
         logic [4:0] sel;
         sel  = d3v ^ 5'(i);
         m[i] = (raw[i] ^ (^sel)) & len[i];
      end
      return m;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge: one-cycle valid strobe, capture edge one clock
   // later, returns at the negedge after the capture edge.
   task automatic cap_word(input logic [31:0] raw, input logic [31:0] vmask,
                           input bit pushes, input bit rdy_cap);
      d1 = raw;
      d2 = vmask;
      @(negedge clk);
      d2 = '0;
      pre_valid = out_valid;
      pre_head  = out_data;
      if (rdy_cap) out_ready = 1'b1;
      @(negedge clk);
      if (rdy_cap) out_ready = 1'b0;
      if (pushes) q.push_back(model_word(raw, d3, lane_en));
   endtask

   task automatic check_head(input string tag);
      logic [31:0] exp;
      exp = (q.size() != 0) ? q.pop_front() : 32'hxxxx_xxxx;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk(tag, out_data, exp);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", out_data, 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      chk("rst_health", 32'(health_fail), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Three words streamed through with out_ready=1
      for (int k = 0; k < 3; k++) begin
         words[k] = $urandom;
         cap_word(words[k], ALL, 1, 0);
         chk("no_bypass", 32'(pre_valid), 0);
         check_head("stream_word");
      end
      @(negedge clk);
      chk("stream_drop", 32'(drop_cnt), 0);
      chk("stream_empty", 32'(out_valid), 0);

      // Upper lanes disabled and never valid
      lane_en = 32'h0000_FFFF;
      d3 = 5'h13;
      cap_word(32'hDEAD_BEEF, 32'h0000_FFFF, 1, 0);
      chk("masked_upper", 32'(out_data[31:16]), 0);
      check_head("masked_word");
      @(negedge clk);
      lane_en = ALL;
      d3 = 5'h00;

      // An edge while en=0 is lost for good
      en = 1'b0;
      cap_word(32'h1357_9BDF, ALL, 0, 0);
      chk("en0_valid", 32'(out_valid), 0);
      en = 1'b1;
      repeat (3) @(negedge clk);
      chk("en0_level", 32'(level), 0);

      // Overflow: six captures into a 4-deep FIFO
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         words[k] = $urandom;
         cap_word(words[k], ALL, k < 4, 0);
      end
      chk("ovf_level", 32'(level), 4);
      chk("ovf_drop", 32'(drop_cnt), 2);
      @(negedge clk);
      chk("ovf_stable", out_data, q[0]);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_head("ovf_drain");
         @(negedge clk);
      end
      chk("ovf_empty", 32'(level), 0);

      // Repetition count: eight identical words
      rct_word = 32'hA5A5_5A5A;
      for (int k = 0; k < 5; k++) begin
         cap_word(rct_word, ALL, 1, 0);
         check_head("rct_push");
      end
      @(negedge clk);
      out_ready = 1'b0;
      cap_word(rct_word, ALL, 1, 0);
      cap_word(rct_word, ALL, 1, 0);
      chk("rct_level7", 32'(level), 2);
      chk("rct_no_fail7", 32'(health_fail), 0);
      cap_word(rct_word, ALL, 0, 0);
      q.delete();
      chk("rct_fail", 32'(health_fail), 1);
      chk("rct_flush_level", 32'(level), 0);
      chk("rct_flush_valid", 32'(out_valid), 0);
      cap_word(32'h1234_5678, ALL, 0, 0);
      chk("rct_ignored_level", 32'(level), 0);
      chk("rct_ignored_drop", 32'(drop_cnt), 2);
      health_clr = 1'b1;
      @(negedge clk);
      health_clr = 1'b0;
      chk("rct_cleared", 32'(health_fail), 0);
      cap_word(rct_word, ALL, 1, 0);
      chk("rct_after_clr_level", 32'(level), 1);
      chk("rct_after_clr_data", out_data, q[0]);

      // Build level=3, drop_cnt=5, then asynchronous reset
      for (int k = 0; k < 6; k++) cap_word($urandom, ALL, k < 3, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      void'(q.pop_front());
      chk("pre_rst_level", 32'(level), 3);
      chk("pre_rst_drop", 32'(drop_cnt), 5);
      #2;
      rst = 1'b0;
      #1;
      chk("async_valid", 32'(out_valid), 0);
      chk("async_data", out_data, 0);
      chk("async_level", 32'(level), 0);
      chk("async_drop", 32'(drop_cnt), 0);
      chk("async_health", 32'(health_fail), 0);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_level", 32'(level), 0);

      // Full FIFO with capture and pop in the same cycle
      for (int k = 0; k < 4; k++) cap_word($urandom, ALL, 1, 0);
      chk("full_level", 32'(level), 4);
      cap_word($urandom, ALL, 1, 1);
      chk("simul_popped_head", pre_head, q[0]);
      void'(q.pop_front());
      chk("simul_level", 32'(level), 4);
      chk("simul_drop", 32'(drop_cnt), 0);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_head("simul_drain");
         @(negedge clk);
      end
      chk("final_empty", 32'(out_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
